// File: rtl/sd_block_writer.sv
// SPI-mode SD block writer: copies 256 words from memory into a local buffer, then writes them with CMD24.
// Define SDW_CRC16_EN to send a real CRC16-CCITT; otherwise the CRC bytes are 0xFF. CLK_DIV must be >= 1.
module sd_block_writer #(
    parameter int CLK_DIV      = 5,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic        clkCPU,
    input  logic        reset,
    inout  wire  [31:0] data,
    input  logic        read,
    input  logic        write,
    output logic        interupt,
    output logic        SDclk,
    output logic        SDcs,
    output logic        MOSI,
    input  logic        MISO,
    output logic        readMem,
    output logic [31:0] readAddress,
    input  logic [15:0] readValue,
    output logic        stallProcessor
);
    localparam int               DIV_W   = $clog2(CLK_DIV + 2);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV);
    localparam logic [7:0]       TO_LAST = 8'(RESP_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, CMD, R1, GAP, TOKEN, DATA, CRC, DRESP, BUSY, ERR, FIN
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      blk_addr_q, blk_addr_d, mem_addr_q, mem_addr_d;
    logic [8:0]       index_q, index_d;
    logic [9:0]       cnt_q, cnt_d;
    logic [7:0]       to_q, to_d;
    logic             error_q, error_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       edge_q, edge_d;
    logic             sclk_q, sclk_d;
    logic [7:0]       tx_q, tx_d, rx_q, rx_d;
    logic             done_q, done_d;
    logic [15:0]      wbuf [256];

    logic             run, tick;
    logic [9:0]       nxt_idx;
    logic [15:0]      nxt_word;
    logic [7:0]       nxt_dbyte, cmd_byte, crc_hi, crc_lo, to_inc;

    assign run       = (state_q != IDLE) && (state_q != FETCH);
    assign tick      = run && (div_q == DIV_MAX);
    assign nxt_idx   = (state_q == TOKEN) ? 10'd0 : cnt_q + 10'd1;
    assign nxt_word  = wbuf[nxt_idx[8:1]];
    assign nxt_dbyte = nxt_idx[0] ? nxt_word[7:0] : nxt_word[15:8];
    assign to_inc    = (to_q == 8'hFF) ? to_q : to_q + 8'd1;

    assign SDclk          = sclk_q;
    assign MOSI           = tx_q[7];
    assign SDcs           = !(run && (state_q != FIN));
    assign readMem        = (state_q == FETCH) && !index_q[8];
    assign readAddress    = mem_addr_q + {23'b0, index_q};
    assign stallProcessor = (state_q == FETCH);
    assign data           = read ? {30'b0, error_q, state_q != IDLE} : 32'bz;

    // cnt_q is the command byte just finished; pick the one after it
    always_comb begin
        cmd_byte = 8'hFF;
        case (cnt_q[2:0])
            3'd0:    cmd_byte = blk_addr_q[31:24];
            3'd1:    cmd_byte = blk_addr_q[23:16];
            3'd2:    cmd_byte = blk_addr_q[15:8];
            3'd3:    cmd_byte = blk_addr_q[7:0];
            default: cmd_byte = 8'hFF;
        endcase
    end

`ifdef SDW_CRC16_EN
    logic [15:0] crc_q, crc_d;
    assign crc_hi = crc_q[15:8];
    assign crc_lo = crc_q[7:0];
    // one CRC step per data bit, taken as the card samples it on the rising edge
    always_comb begin
        crc_d = crc_q;
        if (state_q == TOKEN)
            crc_d = 16'h0000;
        else if ((state_q == DATA) && tick && !sclk_q)
            crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ tx_q[7]) ? 16'h1021 : 16'h0000);
    end
    always_ff @(posedge clkCPU or posedge reset) begin
        if (reset) crc_q <= 16'h0000;
        else       crc_q <= crc_d;
    end
`else
    assign crc_hi = 8'hFF;
    assign crc_lo = 8'hFF;
`endif

    always_comb begin
        state_d    = state_q;
        blk_addr_d = blk_addr_q;
        mem_addr_d = mem_addr_q;
        index_d    = index_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        error_d    = error_q;
        div_d      = '0;
        edge_d     = 4'd0;
        sclk_d     = 1'b0;
        tx_d       = tx_q;
        rx_d       = rx_q;
        done_d     = 1'b0;
        interupt   = 1'b0;

        // byte engine free-runs so consecutive bytes abut; the FSM reloads tx on done_q
        if (run) begin
            div_d  = tick ? '0 : div_q + 1'b1;
            edge_d = edge_q;
            sclk_d = sclk_q;
            if (tick) begin
                sclk_d = ~sclk_q;
                edge_d = edge_q + 4'd1;
                if (!sclk_q) begin
                    rx_d = {rx_q[6:0], MISO};
                end else begin
                    tx_d   = {tx_q[6:0], 1'b1};
                    done_d = (edge_q == 4'd15);
                end
            end
        end

        case (state_q)
            IDLE: if (write) begin
                case (data[31:30])
                    2'b00: blk_addr_d = {data[22:0], 9'b0};
                    2'b01: mem_addr_d = {2'b00, data[29:0]};
                    2'b11: begin
                        error_d = 1'b0;
                        index_d = 9'd0;
                        state_d = FETCH;
                    end
                    default: ;
                endcase
            end
            FETCH: begin
                index_d = index_q + 9'd1;
                if (index_q == 9'd256) begin
                    index_d = index_q;
                    cnt_d   = 10'd0;
                    tx_d    = 8'h58;
                    state_d = CMD;
                end
            end
            CMD: if (done_q) begin
                if (cnt_q == 10'd5) begin
                    tx_d    = 8'hFF;
                    to_d    = 8'd0;
                    state_d = R1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                    tx_d  = cmd_byte;
                end
            end
            R1: if (done_q) begin
                tx_d = 8'hFF;
                if (rx_q != 8'hFF)       state_d = (rx_q == 8'h00) ? GAP : ERR;
                else if (to_q == TO_LAST) state_d = ERR;
                else                      to_d = to_inc;
            end
            GAP: if (done_q) begin
                tx_d    = 8'hFE;
                state_d = TOKEN;
            end
            TOKEN: if (done_q) begin
                tx_d    = nxt_dbyte;
                cnt_d   = 10'd0;
                state_d = DATA;
            end
            DATA: if (done_q) begin
                if (cnt_q == 10'd511) begin
                    tx_d    = crc_hi;
                    cnt_d   = 10'd0;
                    state_d = CRC;
                end else begin
                    tx_d  = nxt_dbyte;
                    cnt_d = nxt_idx;
                end
            end
            CRC: if (done_q) begin
                if (cnt_q[0]) begin
                    tx_d    = 8'hFF;
                    state_d = DRESP;
                end else begin
                    tx_d  = crc_lo;
                    cnt_d = 10'd1;
                end
            end
            DRESP: if (done_q) begin
                tx_d    = 8'hFF;
                to_d    = 8'd0;
                state_d = (rx_q[4:0] == 5'h05) ? BUSY : ERR;
            end
            BUSY: if (done_q) begin
                tx_d = 8'hFF;
                if (rx_q != 8'h00)        state_d = FIN;
                else if (to_q == TO_LAST) state_d = ERR;
                else                      to_d = to_inc;
            end
            ERR: begin
                error_d = 1'b1;
                state_d = FIN;
            end
            FIN: if (done_q) begin
                interupt = 1'b1;
                tx_d     = 8'hFF;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkCPU or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            blk_addr_q <= 32'd0;
            mem_addr_q <= 32'd0;
            index_q    <= 9'd0;
            cnt_q      <= 10'd0;
            to_q       <= 8'd0;
            error_q    <= 1'b0;
            div_q      <= '0;
            edge_q     <= 4'd0;
            sclk_q     <= 1'b0;
            tx_q       <= 8'hFF;
            rx_q       <= 8'hFF;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_addr_q <= blk_addr_d;
            mem_addr_q <= mem_addr_d;
            index_q    <= index_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            error_q    <= error_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            sclk_q     <= sclk_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            done_q     <= done_d;
        end
    end

    // readValue answers the request of the previous cycle, hence index-1
    always_ff @(posedge clkCPU) begin
        if ((state_q == FETCH) && (index_q != 9'd0))
            wbuf[index_q[7:0] - 8'd1] <= readValue;
    end
endmodule

// File: tb/tb_sd_block_writer.sv
// Scoreboard bench for sd_block_writer: stimulus queues expected MOSI bytes, a card/memory monitor pops and compares.
module tb_sd_block_writer;
    localparam int CLK_DIV = 1;

    logic        clkCPU = 1'b0;
    logic        reset  = 1'b1;
    logic        read   = 1'b0;
    logic        write  = 1'b0;
    logic        MISO   = 1'b1;
    logic [15:0] readValue = 16'h0000;
    logic        interupt, SDclk, SDcs, MOSI, readMem, stallProcessor;
    logic [31:0] readAddress;
    wire  [31:0] data;
    logic [31:0] tb_data = 32'h0;
    logic        tb_drv  = 1'b0;

    assign data = tb_drv ? tb_data : 32'bz;

    sd_block_writer #(.CLK_DIV(CLK_DIV), .RESP_TIMEOUT(255)) dut (
        .clkCPU(clkCPU), .reset(reset), .data(data), .read(read), .write(write),
        .interupt(interupt), .SDclk(SDclk), .SDcs(SDcs), .MOSI(MOSI), .MISO(MISO),
        .readMem(readMem), .readAddress(readAddress), .readValue(readValue),
        .stallProcessor(stallProcessor)
    );

    always #5 clkCPU = ~clkCPU;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // shared between stimulus (writer) and monitor (reader/popper)
    logic [7:0]  exp_q[$];
    logic [7:0]  miso_q[$];
    logic [7:0]  miso_fill = 8'hFF;
    logic        all_ones  = 1'b0;
    logic [31:0] addr_base = 32'h0;

    // monitor-owned counters; stimulus uses snapshots
    int nbytes = 0, hi_cnt = 0, stall_cnt = 0, rd_cnt = 0, irq_cnt = 0, irq_hi = 0, fe_seen = 0;

    function automatic logic [15:0] memf(input logic [31:0] a);
        if (all_ones) return 16'hFFFF;
        return {a[7:0] ^ 8'h3C, a[7:0] + 8'h11};
    endfunction

    function automatic logic [7:0] next_miso();
        if (miso_q.size() > 0) return miso_q.pop_front();
        return miso_fill;
    endfunction

    logic [15:0] pend = 16'hDEAD;
    logic [7:0]  rx_sh = 8'h00, miso_sh = 8'hFF, e;
    int          bitn = 0, rd_idx = 0;
    logic        cs_prev = 1'b1, sclk_prev = 1'b0, irq_prev = 1'b0;

    always @(negedge clkCPU) begin
        readValue = pend;
        pend = readMem ? memf(readAddress) : 16'hDEAD;
        if (stallProcessor) stall_cnt++;
        if (!stallProcessor) rd_idx = 0;
        if (readMem) begin
            chk("readAddress", readAddress, addr_base + rd_idx);
            rd_idx++;
            rd_cnt++;
        end
        if (interupt) irq_hi++;
        if (interupt && !irq_prev) irq_cnt++;
        irq_prev = interupt;

        if (SDcs) begin
            bitn = 0;
            MISO = 1'b1;
        end else begin
            if (cs_prev) begin
                miso_sh = next_miso();
                MISO    = miso_sh[7];
                bitn    = 0;
            end
            if (SDclk) hi_cnt++;
            if (SDclk && !sclk_prev) begin
                rx_sh = {rx_sh[6:0], MOSI};
                bitn++;
            end
            if (!SDclk && sclk_prev) begin
                if (bitn == 8) begin
                    nbytes++;
                    if (rx_sh == 8'hFE) fe_seen++;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("mosi_byte", {24'h0, rx_sh}, {24'h0, e});
                    end
                    miso_sh = next_miso();
                    bitn    = 0;
                end else begin
                    miso_sh = {miso_sh[6:0], 1'b1};
                end
                MISO = miso_sh[7];
            end
        end
        cs_prev   = SDcs;
        sclk_prev = SDclk;
    end

    task automatic wr(input logic [31:0] v);
        @(negedge clkCPU);
        tb_data = v; tb_drv = 1'b1; write = 1'b1;
        @(negedge clkCPU);
        write = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic rd_status(output logic [31:0] v);
        @(negedge clkCPU);
        read = 1'b1;
        #1 v = data;
        @(negedge clkCPU);
        read = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(b);
    endtask

    task automatic push_miso(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) miso_q.push_back(b);
    endtask

    task automatic push_cmd();
        exp_q.push_back(8'h58); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h06); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    endtask

    task automatic push_data();
        logic [15:0] w;
        for (int k = 0; k < 256; k++) begin
            w = memf(32'h1000 + k);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
    endtask

    task automatic wait_irq(input int base, input int maxc);
        int i;
        i = 0;
        while (irq_cnt == base && i < maxc) begin
            @(negedge clkCPU);
            i++;
        end
        chk("irq_arrived", {31'b0, irq_cnt != base}, 32'd1);
        repeat (4) @(negedge clkCPU);
    endtask

    task automatic wait_bytes(input int target, input int maxc);
        int i;
        i = 0;
        while (nbytes < target && i < maxc) begin
            @(negedge clkCPU);
            i++;
        end
        chk("bytes_reached", {31'b0, nbytes >= target}, 32'd1);
    endtask

    logic [31:0] st;
    int b_bytes, b_hi, b_stall, b_rd, b_irq, b_irqhi, b_fe;

    task automatic snap();
        b_bytes = nbytes; b_hi = hi_cnt; b_stall = stall_cnt; b_rd = rd_cnt;
        b_irq = irq_cnt; b_irqhi = irq_hi; b_fe = fe_seen;
    endtask

    initial begin
        #12;
        chk("rst_SDcs", {31'b0, SDcs}, 32'd1);
        chk("rst_SDclk", {31'b0, SDclk}, 32'd0);
        chk("rst_MOSI", {31'b0, MOSI}, 32'd1);
        chk("rst_irq", {31'b0, interupt}, 32'd0);
        chk("rst_readMem", {31'b0, readMem}, 32'd0);
        chk("rst_stall", {31'b0, stallProcessor}, 32'd0);
        chk("rst_readAddress", readAddress, 32'd0);
        @(negedge clkCPU);
        reset = 1'b0;
        rd_status(st);
        chk("rst_status", st, 32'd0);

        // full write, with commands issued mid-DATA that must be ignored
        addr_base = 32'h1000; all_ones = 1'b0; miso_fill = 8'hFF;
        miso_q.delete();
        push_miso(8'hFF, 6); push_miso(8'h00, 1); push_miso(8'hFF, 2); push_miso(8'hFF, 512);
        push_miso(8'hFF, 2); push_miso(8'hE5, 1); push_miso(8'h00, 3); push_miso(8'hFF, 1);
        push_cmd(); push_exp(8'hFF, 2); push_exp(8'hFE, 1); push_data();
        push_exp(8'hFF, 2); push_exp(8'hFF, 1); push_exp(8'hFF, 4);
        snap();
        wr(32'h0000_0003);
        wr(32'h4000_1000);
        wr(32'hC000_0000);
        wait_bytes(b_bytes + 20, 5000);
        wr(32'hC000_0000);
        wr(32'h4000_2000);
        wr(32'h0000_0077);
        rd_status(st);
        chk("busy_status_in_data", st, 32'd1);
        wait_irq(b_irq, 30000);
        chk("A_stall_cycles", stall_cnt - b_stall, 32'd257);
        chk("A_readMem_cycles", rd_cnt - b_rd, 32'd256);
        chk("A_bytes", nbytes - b_bytes, 32'd528);
        chk("A_exp_drained", exp_q.size(), 32'd0);
        chk("A_irq_count", irq_cnt - b_irq, 32'd1);
        chk("A_irq_width", irq_hi - b_irqhi, 32'd1);
        chk("A_SDcs", {31'b0, SDcs}, 32'd1);
        rd_status(st);
        chk("A_status", st, 32'd0);

        // rejected command: R1 = 0x04
        miso_q.delete();
        push_miso(8'hFF, 6); push_miso(8'h04, 1);
        push_cmd(); push_exp(8'hFF, 1);
        snap();
        wr(32'hC000_0000);
        wait_irq(b_irq, 5000);
        chk("B_bytes", nbytes - b_bytes, 32'd7);
        chk("B_no_token", fe_seen - b_fe, 32'd0);
        chk("B_sclk_high_cycles", hi_cnt - b_hi, 32'd112);
        chk("B_stall_cycles", stall_cnt - b_stall, 32'd257);
        chk("B_irq_count", irq_cnt - b_irq, 32'd1);
        chk("B_SDcs", {31'b0, SDcs}, 32'd1);
        rd_status(st);
        chk("B_status", st, 32'd2);

        // R1 never arrives
        miso_q.delete();
        miso_fill = 8'hFF;
        push_cmd();
        snap();
        wr(32'hC000_0000);
        rd_status(st);
        chk("C_error_cleared", st, 32'd1);
        wait_irq(b_irq, 20000);
        chk("C_bytes", nbytes - b_bytes, 32'd261);
        chk("C_exp_drained", exp_q.size(), 32'd0);
        rd_status(st);
        chk("C_status", st, 32'd2);

        // card stuck busy; all-0xFF block also exercises the CRC bytes
        miso_q.delete();
        all_ones = 1'b1;
        push_miso(8'hFF, 6); push_miso(8'h00, 1); push_miso(8'hFF, 514);
        push_miso(8'hFF, 2); push_miso(8'hE5, 1);
        push_cmd(); push_exp(8'hFF, 2); push_exp(8'hFE, 1); push_data();
`ifdef SDW_CRC16_EN
        push_exp(8'h7F, 1); push_exp(8'hA1, 1);
`else
        push_exp(8'hFF, 2);
`endif
        push_exp(8'hFF, 1);
        snap();
        wr(32'hC000_0000);
        miso_fill = 8'h00;
        rd_status(st);
        chk("D_error_cleared", st, 32'd1);
        wait_irq(b_irq, 40000);
        chk("D_bytes", nbytes - b_bytes, 32'd779);
        chk("D_exp_drained", exp_q.size(), 32'd0);
        chk("D_irq_count", irq_cnt - b_irq, 32'd1);
        rd_status(st);
        chk("D_status", st, 32'd2);

        // reset in the middle of DATA
        miso_q.delete();
        all_ones = 1'b0; miso_fill = 8'hFF;
        push_miso(8'hFF, 6); push_miso(8'h00, 1);
        snap();
        wr(32'hC000_0000);
        wait_bytes(b_bytes + 30, 5000);
        @(negedge clkCPU);
        #2 reset = 1'b1;
        #1;
        chk("E_SDcs_async", {31'b0, SDcs}, 32'd1);
        chk("E_SDclk", {31'b0, SDclk}, 32'd0);
        repeat (3) @(negedge clkCPU);
        reset = 1'b0;
        rd_status(st);
        chk("E_status", st, 32'd0);
        repeat (300) @(negedge clkCPU);
        chk("E_no_irq", irq_cnt - b_irq, 32'd0);
        chk("E_SDcs_idle", {31'b0, SDcs}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
